avlst2mm_multibuf: RTL and testbench
====================================

Name: avlst2mm_multibuf

Overview:
- Parametrised successor of the video stream-to-memory bridge.
- Takes a pixel Avalon-ST stream (one pixel per word, frame delimited by sop/eop) and writes each frame into DRAM as Avalon-MM write bursts.
- Writes target one of NB_BUF frame buffers. The buffer is chosen per frame, either by automatic rotation or by a manual select, and latched at frame start. This replaces the static two-buffer address mux.
- Sits between the video source and the f2h SDRAM host port. Reports the last completed buffer to the display reader.

Parameters:
- DATA_W, 32, stream/MM data width in bits; must be a multiple of 8.
- ADDR_W, 32, MM byte address width.
- BURST_LEN, 16, maximum words per burst; power of 2.
- FIFO_DEPTH, 64, internal FIFO words; power of 2, at least 2*BURST_LEN.
- NB_BUF, 2, number of frame buffers; at least 1.
- BASE_ADDR, 32'h3800_0000, byte address of buffer 0.
- BUF_STRIDE, 32'h0017_7000, byte distance between consecutive buffers.
- FRAME_WORDS, 384000, words per frame (800x480).

Ports:
- sys_clk  in  1  single clock.
- sys_rst  in  1  asynchronous, active-high reset.
- auto_swap  in  1  1: rotate buffers each frame; 0: use buf_sel.
- buf_sel  in  $clog2(NB_BUF) (min 1)  manual buffer index.
- st_data  in  DATA_W  pixel word.
- st_valid  in  1  stream valid.
- st_ready  out  1  stream ready.
- st_sop  in  1  first word of frame.
- st_eop  in  1  last word of frame.
- mm_address  out  ADDR_W  burst start byte address.
- mm_write  out  1  write request.
- mm_writedata  out  DATA_W  write data.
- mm_byteenable  out  DATA_W/8  always all ones.
- mm_burstcount  out  $clog2(BURST_LEN)+1  words in burst.
- mm_waitrequest  in  1  agent stall.
- cur_buf  out  $clog2(NB_BUF)  buffer of the frame in progress.
- last_buf  out  $clog2(NB_BUF)  last completely written buffer.
- frame_done  out  1  one-cycle pulse when a frame is fully written.
- frame_err  out  1  one-cycle pulse on a length mismatch.

Behaviour:
- Reset values: st_ready=0, mm_write=0, mm_address=0, mm_burstcount=0, mm_writedata=0, cur_buf=NB_BUF-1, last_buf=NB_BUF-1, frame_done=0, frame_err=0. FIFO is empty; both FSMs are idle.
- A word transfers when st_valid && st_ready.
- Input FSM:
  - IN_IDLE: st_ready=1. Words without sop are discarded. A sop word latches cur_buf, clears in_cnt and wr_cnt, is pushed, and moves to IN_FRAME.
  - Buffer choice at sop: auto_swap=1 gives (cur_buf+1) mod NB_BUF. Otherwise buf_sel, with values of NB_BUF or more clamped to NB_BUF-1.
  - IN_FRAME: st_ready = !fifo_full. Each accepted word is pushed and increments in_cnt. A sop seen inside a frame is treated as data.
  - IN_FRAME, eop word pushed: go to IN_DRAIN. If in_cnt+1 < FRAME_WORDS, pulse frame_err on the next cycle.
  - IN_FRAME, word number FRAME_WORDS pushed without eop: go to IN_SKIP.
  - IN_SKIP: st_ready=1; words are discarded. On an eop word, pulse frame_err and go to IN_DRAIN.
  - IN_DRAIN: st_ready=0. When the FIFO is empty and the writer is in W_IDLE: pulse frame_done, set last_buf=cur_buf, go to IN_IDLE.
- Writer FSM:
  - W_IDLE: launch a burst when fifo_count >= BURST_LEN, or when input is in IN_DRAIN/IN_SKIP and fifo_count > 0.
  - Burst size n = min(fifo_count, BURST_LEN), latched at launch.
  - Latched address = BASE_ADDR + cur_buf*BUF_STRIDE + wr_cnt*(DATA_W/8), computed in ADDR_W bits; wrap-around is ignored.
  - mm_write rises the cycle after launch.
  - W_BURST: mm_write=1 continuously, with no gaps. mm_writedata = FIFO head (show-ahead).
  - A word is accepted on each cycle with mm_write && !mm_waitrequest; it is popped and wr_cnt increments.
  - mm_address and mm_burstcount are held for the whole burst.
  - After word n: mm_write=0 and return to W_IDLE. There is a minimum of one idle cycle between bursts.
- Push and pop in the same cycle are both honoured; fifo_count is unchanged.
- Reset mid-burst: all state is cleared immediately and the partial frame is lost. The interconnect shares the same reset.

Test Plan:
1. FRAME_WORDS=40, BURST_LEN=16, NB_BUF=2, auto_swap=1, waitrequest=0; one 40-word frame -> bursts at 0x3800_0000/16, 0x3800_0040/16, 0x3800_0080/8; frame_done pulse; cur_buf=0, last_buf=0.
2. Three consecutive frames -> base addresses 0x3817_7000, then 0x3800_0000, then 0x3817_7000; last_buf sequence 1,0,1.
3. Random 50% waitrequest and st_valid -> written data equals the input sequence; address/burstcount stable within each burst; no mm_write gap inside a burst.
4. eop at word 25 -> bursts 16 and 9; frame_err pulse; frame_done pulse.
5. 45 words, eop on word 45 -> exactly 40 words written; 5 discarded; one frame_err pulse.
6. auto_swap=0, buf_sel=1; 3 non-sop words before sop -> discarded, frame at 0x3817_7000. Assert sys_rst mid-burst -> all outputs at reset values the same cycle.

Source files
------------

// File: rtl/avlst2mm_multibuf.sv
// Pixel Avalon-ST to Avalon-MM burst writer with NB_BUF rotating/selectable frame buffers.
// Each frame is pushed through a show-ahead FIFO and written as bursts of at most BURST_LEN words.
module avlst2mm_multibuf #(
    parameter int                DATA_W      = 32,
    parameter int                ADDR_W      = 32,
    parameter int                BURST_LEN   = 16,
    parameter int                FIFO_DEPTH  = 64,
    parameter int                NB_BUF      = 2,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = 32'h3800_0000,
    parameter logic [ADDR_W-1:0] BUF_STRIDE  = 32'h0017_7000,
    parameter int                FRAME_WORDS = 384000,
    localparam int               BUF_W       = (NB_BUF > 1) ? $clog2(NB_BUF) : 1,
    localparam int               BC_W        = $clog2(BURST_LEN) + 1
) (
    input  logic                sys_clk,
    input  logic                sys_rst,
    input  logic                auto_swap,
    input  logic [BUF_W-1:0]    buf_sel,
    input  logic [DATA_W-1:0]   st_data,
    input  logic                st_valid,
    output logic                st_ready,
    input  logic                st_sop,
    input  logic                st_eop,
    output logic [ADDR_W-1:0]   mm_address,
    output logic                mm_write,
    output logic [DATA_W-1:0]   mm_writedata,
    output logic [DATA_W/8-1:0] mm_byteenable,
    output logic [BC_W-1:0]     mm_burstcount,
    input  logic                mm_waitrequest,
    output logic [BUF_W-1:0]    cur_buf,
    output logic [BUF_W-1:0]    last_buf,
    output logic                frame_done,
    output logic                frame_err
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CF = $clog2(FIFO_DEPTH + 1);
    localparam int CW = $clog2(FRAME_WORDS + 1);

    localparam logic [CF-1:0]     BL_F       = CF'(BURST_LEN);
    localparam logic [CF-1:0]     FIFO_FULL  = CF'(FIFO_DEPTH);
    localparam logic [CW-1:0]     FW         = CW'(FRAME_WORDS);
    localparam logic [CW-1:0]     ONE_W      = CW'(1);
    localparam logic [BUF_W-1:0]  LAST_IDX   = BUF_W'(NB_BUF - 1);
    localparam logic [BUF_W:0]    NB_X       = (BUF_W + 1)'(NB_BUF);
    localparam logic [ADDR_W-1:0] WORD_BYTES = ADDR_W'(DATA_W / 8);
    localparam logic [BC_W-1:0]   BC_ONE     = BC_W'(1);

    typedef enum logic [1:0] {IN_IDLE, IN_FRAME, IN_SKIP, IN_DRAIN} in_state_t;
    typedef enum logic {W_IDLE, W_BURST} w_state_t;

    in_state_t in_state, in_next;
    w_state_t  w_state, w_next;

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]     wp, rp;
    logic [CF-1:0]     fcnt;
    logic              fifo_full;
    logic              push, pop;

    logic [CW-1:0]     in_cnt, wr_cnt;
    logic [BUF_W-1:0]  next_buf;
    logic              run, sop_take, err_set, done_set;

    logic              launch;
    logic [BC_W-1:0]   beats, burst_n;
    logic [ADDR_W-1:0] burst_addr;

    assign fifo_full     = (fcnt == FIFO_FULL);
    assign mm_byteenable = '1;
    assign mm_write      = (w_state == W_BURST);
    assign mm_writedata  = mm_write ? mem[rp] : '0;

    // Buffer chosen for the next frame; out-of-range manual selections clamp to the top buffer.
    always_comb begin
        next_buf = buf_sel;
        if (auto_swap) begin
            next_buf = (cur_buf == LAST_IDX) ? '0 : cur_buf + 1'b1;
        end else if ({1'b0, buf_sel} >= NB_X) begin
            next_buf = LAST_IDX;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (push) mem[wp] <= st_data;
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            wp   <= '0;
            rp   <= '0;
            fcnt <= '0;
        end else begin
            if (push) wp <= wp + 1'b1;
            if (pop)  rp <= rp + 1'b1;
            case ({push, pop})
                2'b10:   fcnt <= fcnt + 1'b1;
                2'b01:   fcnt <= fcnt - 1'b1;
                default: fcnt <= fcnt;
            endcase
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            in_state <= IN_IDLE;
            w_state  <= W_IDLE;
        end else begin
            in_state <= in_next;
            w_state  <= w_next;
        end
    end

    // run keeps st_ready low until the first cycle after reset release.
    always_comb begin
        in_next  = in_state;
        st_ready = 1'b0;
        push     = 1'b0;
        sop_take = 1'b0;
        err_set  = 1'b0;
        done_set = 1'b0;
        case (in_state)
            IN_IDLE: begin
                st_ready = run;
                if (run && st_valid && st_sop) begin
                    push     = 1'b1;
                    sop_take = 1'b1;
                    if (st_eop) begin
                        in_next = IN_DRAIN;
                        err_set = (ONE_W < FW);
                    end else if (FW == ONE_W) begin
                        in_next = IN_SKIP;
                    end else begin
                        in_next = IN_FRAME;
                    end
                end
            end
            IN_FRAME: begin
                st_ready = !fifo_full;
                if (st_valid && !fifo_full) begin
                    push = 1'b1;
                    if (st_eop) begin
                        in_next = IN_DRAIN;
                        err_set = (in_cnt + ONE_W < FW);
                    end else if (in_cnt + ONE_W == FW) begin
                        in_next = IN_SKIP;
                    end
                end
            end
            IN_SKIP: begin
                st_ready = 1'b1;
                if (st_valid && st_eop) begin
                    err_set = 1'b1;
                    in_next = IN_DRAIN;
                end
            end
            IN_DRAIN: begin
                if (fcnt == '0 && w_state == W_IDLE) begin
                    done_set = 1'b1;
                    in_next  = IN_IDLE;
                end
            end
            default: in_next = IN_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            run        <= 1'b0;
            in_cnt     <= '0;
            wr_cnt     <= '0;
            cur_buf    <= LAST_IDX;
            last_buf   <= LAST_IDX;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            run        <= 1'b1;
            frame_done <= done_set;
            frame_err  <= err_set;
            if (sop_take) begin
                cur_buf <= next_buf;
                in_cnt  <= ONE_W;
                wr_cnt  <= '0;
            end else begin
                if (push) in_cnt <= in_cnt + ONE_W;
                if (pop)  wr_cnt <= wr_cnt + ONE_W;
            end
            if (done_set) last_buf <= cur_buf;
        end
    end

    // Tail bursts are only allowed once the frame has stopped feeding the FIFO.
    always_comb begin
        burst_n    = (fcnt >= BL_F) ? BC_W'(BURST_LEN) : BC_W'(fcnt);
        burst_addr = BASE_ADDR + ADDR_W'(cur_buf) * BUF_STRIDE + ADDR_W'(wr_cnt) * WORD_BYTES;
    end

    always_comb begin
        w_next = w_state;
        launch = 1'b0;
        pop    = 1'b0;
        case (w_state)
            W_IDLE: begin
                if (fcnt >= BL_F ||
                    ((in_state == IN_DRAIN || in_state == IN_SKIP) && fcnt != '0)) begin
                    launch = 1'b1;
                    w_next = W_BURST;
                end
            end
            W_BURST: begin
                if (!mm_waitrequest) begin
                    pop = 1'b1;
                    if (beats == BC_ONE) w_next = W_IDLE;
                end
            end
            default: w_next = W_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            mm_address    <= '0;
            mm_burstcount <= '0;
            beats         <= '0;
        end else if (launch) begin
            mm_address    <= burst_addr;
            mm_burstcount <= burst_n;
            beats         <= burst_n;
        end else if (pop) begin
            beats <= beats - BC_ONE;
        end
    end

endmodule

// File: tb/tb_avlst2mm_multibuf.sv
// Directed + randomized bench for avlst2mm_multibuf with a frame-level reference model
// and a write-side scoreboard (logic [63:0] exp_q[$] holding {address, data}).
module tb_avlst2mm_multibuf;

    localparam int FW = 40;
    localparam int NB = 2;
    localparam logic [31:0] BASE   = 32'h3800_0000;
    localparam logic [31:0] STRIDE = 32'h0017_7000;

    logic        sys_clk, sys_rst, auto_swap;
    logic [0:0]  buf_sel;
    logic [31:0] st_data;
    logic        st_valid, st_ready, st_sop, st_eop;
    logic [31:0] mm_address;
    logic        mm_write;
    logic [31:0] mm_writedata;
    logic [3:0]  mm_byteenable;
    logic [4:0]  mm_burstcount;
    logic        mm_waitrequest;
    logic [0:0]  cur_buf, last_buf;
    logic        frame_done, frame_err;

    avlst2mm_multibuf #(.FRAME_WORDS(FW)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .auto_swap(auto_swap), .buf_sel(buf_sel),
        .st_data(st_data), .st_valid(st_valid), .st_ready(st_ready), .st_sop(st_sop),
        .st_eop(st_eop), .mm_address(mm_address), .mm_write(mm_write),
        .mm_writedata(mm_writedata), .mm_byteenable(mm_byteenable),
        .mm_burstcount(mm_burstcount), .mm_waitrequest(mm_waitrequest),
        .cur_buf(cur_buf), .last_buf(last_buf), .frame_done(frame_done), .frame_err(frame_err)
    );

    // ---------------- clock ----------------
    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    typedef struct {
        logic [31:0] d;
        logic        s;
        logic        e;
    } word_t;

    word_t       stream_q[$];
    logic [63:0] exp_q[$];
    logic [0:0]  exp_last_q[$];
    logic [4:0]  burst_log[$];
    logic [31:0] addr_log[$];

    int n_cmp = 0, n_bad = 0;
    int done_cnt = 0, err_cnt = 0, beat_total = 0;
    int exp_done = 0, exp_err = 0;
    int beat_idx = 0;
    logic [31:0] b_addr;
    logic [4:0]  b_bc;
    logic wr_rand = 1'b0, gap_en = 1'b0;

    // model state: 0 waiting for sop, 1 collecting, 2 discarding to eop
    int         m_state = 0;
    int         m_cnt = 0;
    logic [0:0] m_buf = 1'b1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic model_stream();
        foreach (stream_q[i]) begin
            if (m_state == 0) begin
                if (!stream_q[i].s) continue;
                if (auto_swap) m_buf = 1'((int'(m_buf) + 1) % NB);
                else m_buf = (int'(buf_sel) >= NB) ? 1'(NB - 1) : buf_sel;
                m_cnt = 0;
                m_state = 1;
            end else if (m_state == 2) begin
                if (stream_q[i].e) begin
                    exp_err++; exp_done++; exp_last_q.push_back(m_buf); m_state = 0;
                end
                continue;
            end
            exp_q.push_back({BASE + 32'(m_buf) * STRIDE + 32'(m_cnt) * 32'd4, stream_q[i].d});
            m_cnt++;
            if (stream_q[i].e) begin
                if (m_cnt < FW) exp_err++;
                exp_done++; exp_last_q.push_back(m_buf); m_state = 0;
            end else if (m_cnt == FW) begin
                m_state = 2;
            end
        end
    endtask

    task automatic add_frame(input int len, input int eop_at);
        word_t w;
        for (int i = 1; i <= len; i++) begin
            w.d = $urandom;
            w.s = (i == 1);
            w.e = (i == eop_at);
            stream_q.push_back(w);
        end
    endtask

    task automatic send_word(input word_t w);
        int guard = 0;
        forever begin
            @(posedge sys_clk); #1;
            if (gap_en && $urandom_range(0, 1) == 0) begin
                st_valid = 1'b0;
            end else begin
                st_valid = 1'b1; st_data = w.d; st_sop = w.s; st_eop = w.e;
                @(negedge sys_clk);
                if (st_ready) break;
            end
            guard++;
            if (guard > 2000) begin
                check("send_timeout", 0, 1);
                break;
            end
        end
    endtask

    task automatic run_stream();
        model_stream();
        foreach (stream_q[i]) send_word(stream_q[i]);
        @(posedge sys_clk); #1;
        st_valid = 1'b0; st_sop = 1'b0; st_eop = 1'b0;
        stream_q.delete();
    endtask

    task automatic wait_done(input int target);
        int k = 0;
        while (done_cnt < target && k < 4000) begin
            @(negedge sys_clk); #1;
            k++;
        end
        check("done_wait", done_cnt >= target, 1);
        repeat (3) @(negedge sys_clk);
        check("exp_q_empty", exp_q.size(), 0);
        check("done_count", done_cnt, exp_done);
        check("err_count", err_cnt, exp_err);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_st_ready"}, st_ready, 0);
        check({tag, "_mm_write"}, mm_write, 0);
        check({tag, "_mm_address"}, mm_address, 0);
        check({tag, "_mm_burstcount"}, mm_burstcount, 0);
        check({tag, "_mm_writedata"}, mm_writedata, 0);
        check({tag, "_cur_buf"}, cur_buf, NB - 1);
        check({tag, "_last_buf"}, last_buf, NB - 1);
        check({tag, "_frame_done"}, frame_done, 0);
        check({tag, "_frame_err"}, frame_err, 0);
    endtask

    // ---------------- waitrequest driver ----------------
    initial begin
        mm_waitrequest = 1'b0;
        forever begin
            @(posedge sys_clk); #1;
            mm_waitrequest = wr_rand ? 1'($urandom_range(0, 1)) : 1'b0;
        end
    end

    // ---------------- write-side scoreboard ----------------
    always @(negedge sys_clk) begin
        if (sys_rst) begin
            beat_idx = 0;
        end else begin
            if (frame_done) begin
                done_cnt++;
                if (exp_last_q.size() == 0) check("last_buf_unexpected", 1, 0);
                else check("last_buf", last_buf, exp_last_q.pop_front());
            end
            if (frame_err) err_cnt++;
            if (beat_idx != 0) check("burst_gap", mm_write, 1);
            if (mm_write && !mm_waitrequest) begin
                if (beat_idx == 0) begin
                    b_addr = mm_address;
                    b_bc   = mm_burstcount;
                    burst_log.push_back(mm_burstcount);
                    addr_log.push_back(mm_address);
                    check("burstcount_range", (mm_burstcount >= 5'd1) && (mm_burstcount <= 5'd16), 1);
                end else begin
                    check("addr_stable", mm_address, b_addr);
                    check("bc_stable", mm_burstcount, b_bc);
                end
                check("byteenable", mm_byteenable, 4'hF);
                if (exp_q.size() == 0) begin
                    check("extra_beat", 1, 0);
                end else begin
                    logic [63:0] e;
                    e = exp_q.pop_front();
                    check("wr_addr", b_addr + 32'(beat_idx) * 32'd4, e[63:32]);
                    check("wr_data", mm_writedata, e[31:0]);
                end
                beat_total++;
                beat_idx++;
                if (beat_idx == int'(b_bc)) beat_idx = 0;
            end
        end
    end

    // ---------------- directed sequence ----------------
    initial begin
        int t_beats, t_err;
        word_t w;
        sys_rst = 1'b1; auto_swap = 1'b1; buf_sel = 1'b0;
        st_data = '0; st_valid = 1'b0; st_sop = 1'b0; st_eop = 1'b0;
        repeat (3) @(posedge sys_clk); #1;
        check_reset_outputs("rst0");
        sys_rst = 1'b0;
        repeat (2) @(negedge sys_clk);
        check("ready_idle", st_ready, 1);

        // single 40-word frame, rotation from buffer 1 to 0
        burst_log.delete(); addr_log.delete();
        add_frame(FW, FW);
        run_stream();
        wait_done(1);
        check("t1_nbursts", burst_log.size(), 3);
        if (burst_log.size() == 3) begin
            check("t1_bc0", burst_log[0], 16);
            check("t1_bc1", burst_log[1], 16);
            check("t1_bc2", burst_log[2], 8);
            check("t1_addr0", addr_log[0], 32'h3800_0000);
            check("t1_addr1", addr_log[1], 32'h3800_0040);
            check("t1_addr2", addr_log[2], 32'h3800_0080);
        end
        check("t1_cur_buf", cur_buf, 0);
        check("t1_last_buf", last_buf, 0);

        // three consecutive frames: buffers 1, 0, 1
        addr_log.delete();
        add_frame(FW, FW); add_frame(FW, FW); add_frame(FW, FW);
        run_stream();
        wait_done(4);
        check("t2_nbursts", addr_log.size(), 9);
        if (addr_log.size() == 9) begin
            check("t2_base0", addr_log[0], 32'h3817_7000);
            check("t2_base1", addr_log[3], 32'h3800_0000);
            check("t2_base2", addr_log[6], 32'h3817_7000);
        end
        check("t2_last_buf", last_buf, 1);

        // random stalls on both sides
        wr_rand = 1'b1; gap_en = 1'b1;
        add_frame(FW, FW); add_frame(FW, FW);
        run_stream();
        wait_done(6);
        wr_rand = 1'b0; gap_en = 1'b0;

        // short frame: eop on word 25
        burst_log.delete();
        t_err = err_cnt;
        add_frame(25, 25);
        run_stream();
        wait_done(7);
        check("t4_nbursts", burst_log.size(), 2);
        if (burst_log.size() == 2) begin
            check("t4_bc0", burst_log[0], 16);
            check("t4_bc1", burst_log[1], 9);
        end
        check("t4_err_pulses", err_cnt - t_err, 1);

        // long frame: 45 words, only the first 40 are written
        t_beats = beat_total; t_err = err_cnt;
        add_frame(45, 45);
        run_stream();
        wait_done(8);
        check("t5_beats", beat_total - t_beats, 40);
        check("t5_err_pulses", err_cnt - t_err, 1);

        // manual select with junk words ahead of sop
        auto_swap = 1'b0; buf_sel = 1'b1;
        addr_log.delete();
        for (int i = 0; i < 3; i++) begin
            w.d = $urandom; w.s = 1'b0; w.e = (i == 1);
            stream_q.push_back(w);
        end
        add_frame(FW, FW);
        run_stream();
        wait_done(9);
        check("t6_base", addr_log.size() > 0 ? addr_log[0] : 32'h0, 32'h3817_7000);
        check("t6_last_buf", last_buf, 1);

        // reset in the middle of a burst
        add_frame(20, 0);
        run_stream();
        begin
            int k = 0;
            while (!mm_write && k < 200) begin
                @(negedge sys_clk); k++;
            end
            check("t6_burst_started", mm_write, 1);
        end
        @(posedge sys_clk); #1;
        sys_rst = 1'b1;
        #1;
        check_reset_outputs("rst_mid");
        exp_q.delete(); exp_last_q.delete();
        m_state = 0; m_buf = 1'b1;
        repeat (2) @(posedge sys_clk); #1;
        sys_rst = 1'b0;

        // recovery frame after reset
        auto_swap = 1'b1;
        addr_log.delete();
        add_frame(FW, FW);
        run_stream();
        wait_done(10);
        check("t7_base", addr_log.size() > 0 ? addr_log[0] : 32'h0, 32'h3800_0000);
        check("t7_last_buf", last_buf, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
